// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 timing constants, coordinate type and the
//            8-entry colour-bar table shared by the VGA sync generator.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [11:0]        rgb_t;

  // Bar 0 sits in the least significant slot: white, yellow, cyan, green,
  // magenta, red, blue, black from left to right of the screen.
  localparam logic [8*12-1:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    return BAR_TABLE[int'(idx)*12 +: 12];
  endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_tick_gen
// Brief    : Pixel clock-enable divider; tick is high one clk in every CLK_DIV.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // A one-bit counter pinned at zero covers CLK_DIV==1: tick is then constant.
  localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);

  logic [C_DIV_W-1:0] r_div_cnt;
  logic               w_last;

  assign w_last = (r_div_cnt == C_DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign tick = w_last;

endmodule : pixel_tick_gen
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA raster timing from the system clock using a pixel enable.
//            Define VGA_SYNC_TEST_PATTERN_EN to add the rgb colour-bar output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pixel_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
`ifdef VGA_SYNC_TEST_PATTERN_EN
  ,
  output logic [11:0]        rgb
`endif
);

  localparam int C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t C_H_LAST     = COORD_W'(C_H_TOTAL - 1);
  localparam coord_t C_V_LAST     = COORD_W'(C_V_TOTAL - 1);
  localparam coord_t C_H_VIS      = COORD_W'(H_VISIBLE);
  localparam coord_t C_V_VIS      = COORD_W'(V_VISIBLE);
  localparam coord_t C_HS_FIRST   = COORD_W'(H_VISIBLE + H_FRONT);
  localparam coord_t C_HS_LAST    = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t C_VS_FIRST   = COORD_W'(V_VISIBLE + V_FRONT);
  localparam coord_t C_VS_LAST    = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic   w_tick;
  coord_t w_x_next;
  coord_t w_y_next;
  logic   w_x_wrap;
  logic   w_hs_on;
  logic   w_vs_on;
  logic   w_video_next;

  coord_t r_x;
  coord_t r_y;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_video_on;
  logic   r_pixel_tick;
  logic   r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Decode is done on the next coordinates so the registered syncs and
  // video_on line up with the registered x/y in the same cycle.
  always_comb begin
    w_x_wrap = (r_x == C_H_LAST);
    w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = (r_y == C_V_LAST) ? '0 : r_y + 1'b1;
    end
    w_hs_on      = (w_x_next >= C_HS_FIRST) && (w_x_next <= C_HS_LAST);
    w_vs_on      = (w_y_next >= C_VS_FIRST) && (w_y_next <= C_VS_LAST);
    w_video_next = (w_x_next < C_H_VIS) && (w_y_next < C_V_VIS);
  end

  // Reset parks the raster on the final back-porch pixel so the first
  // enable lands on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= C_H_LAST;
      r_y           <= C_V_LAST;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_video_on    <= 1'b0;
      r_pixel_tick  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_tick  <= w_tick;
      r_frame_start <= w_tick && (w_x_next == '0) && (w_y_next == '0);
      if (w_tick) begin
        r_x        <= w_x_next;
        r_y        <= w_y_next;
        r_hsync    <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_vsync    <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_video_on <= w_video_next;
      end
    end
  end

  assign pixel_tick  = r_pixel_tick;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign x           = r_x;
  assign y           = r_y;

`ifdef VGA_SYNC_TEST_PATTERN_EN
  localparam coord_t C_BAR_W = COORD_W'(H_VISIBLE / 8);

  logic [2:0] w_bar_idx;
  rgb_t       w_rgb_next;
  rgb_t       r_rgb;

  always_comb begin
    w_bar_idx  = 3'(w_x_next / C_BAR_W);
    w_rgb_next = w_video_next ? bar_colour(w_bar_idx) : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= 12'h000;
    end else if (w_tick) begin
      r_rgb <= w_rgb_next;
    end
  end

  assign rgb = r_rgb;
`endif

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Self-checking bench: a full-size CLK_DIV=4 raster and a reduced
//            CLK_DIV=1 raster with random resets, both against a pixel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic       a_tick, a_fs, a_hs, a_vs, a_von;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_fs, b_hs, b_vs, b_von;
  logic [9:0] b_x, b_y;
  logic [11:0] a_rgb, b_rgb;

  vga_sync_gen #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .reset(rst_a), .pixel_tick(a_tick), .frame_start(a_fs),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .x(a_x), .y(a_y)
`ifdef VGA_SYNC_TEST_PATTERN_EN
    , .rgb(a_rgb)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .pixel_tick(b_tick), .frame_start(b_fs),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .x(b_x), .y(b_y)
`ifdef VGA_SYNC_TEST_PATTERN_EN
    , .rgb(b_rgb)
`endif
  );

`ifndef VGA_SYNC_TEST_PATTERN_EN
  assign a_rgb = 12'h000;
  assign b_rgb = 12'h000;
`endif

  int n_err = 0;
  int n_chk = 0;
  int ka    = 0;
  int kb    = 0;
  bit mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pixel model: after k enabled edges since release, n=k/d pixels have been
  // shown; pixel n lives at linear raster address n-1 modulo the frame size.
  function automatic logic [63:0] model(input int k, input int d,
                                        input int hv, input int hf, input int hs, input int hb,
                                        input int vv, input int vf, input int vs, input int vb);
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int ht = hv + hf + hs + hb;
    int vt = vv + vf + vs + vb;
    int n  = k / d;
    int p, px, py;
    logic tk, fs, h, v, von;
    logic [11:0] col;
    if (n == 0) begin
      px = ht - 1; py = vt - 1; tk = 1'b0; fs = 1'b0;
    end else begin
      p  = (n - 1) % (ht * vt);
      px = p % ht;
      py = p / ht;
      tk = (k % d) == 0;
      fs = tk && (p == 0);
    end
    h   = !(px >= hv + hf && px < hv + hf + hs);
    v   = !(py >= vv + vf && py < vv + vf + vs);
    von = (n != 0) && (px < hv) && (py < vv);
`ifdef VGA_SYNC_TEST_PATTERN_EN
    col = von ? bars[px / (hv / 8)] : 12'h000;
`else
    col = 12'h000;
`endif
    return {27'd0, col, tk, fs, h, v, von, 10'(px), 10'(py)};
  endfunction

  always @(posedge clk) begin
    ka = rst_a ? 0 : ka + 1;
    kb = rst_b ? 0 : kb + 1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("A_raster", {27'd0, a_rgb, a_tick, a_fs, a_hs, a_vs, a_von, a_x, a_y},
                model(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      check_val("B_raster", {27'd0, b_rgb, b_tick, b_fs, b_hs, b_vs, b_von, b_x, b_y},
                model(kb, 1, 16, 2, 3, 3, 8, 2, 2, 3));
    end
  end

  task automatic wait_a_x(input int tx, input int ty, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (a_tick && a_x == 10'(tx) && a_y == 10'(ty)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic a_seq();
    int ticks = 0;
    int hmin = 1023;
    int hmax = 0;
    bit ok;
    repeat (4) @(negedge clk);
    check_val("A_first_pixel", {a_x, a_y, a_von, a_tick, a_fs}, {10'd0, 10'd0, 3'b111});
`ifdef VGA_SYNC_TEST_PATTERN_EN
    check_val("A_rgb_x0", a_rgb, 12'hFFF);
`endif
    repeat (3200) begin
      @(negedge clk);
      if (a_tick) ticks++;
      if (!a_hs) begin
        if (a_x < hmin) hmin = a_x;
        if (a_x > hmax) hmax = a_x;
      end
    end
    check_val("A_line_ticks", ticks, 800);
    check_val("A_line_wrap", {a_x, a_y}, {10'd0, 10'd1});
    check_val("A_hsync_first", hmin, 656);
    check_val("A_hsync_last", hmax, 751);

    wait_a_x(300, 1, ok);
    check_val("A_reach_300", ok, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check_val("A_midreset", {a_x, a_y, a_von, a_hs, a_vs, a_tick, a_fs},
              {10'd799, 10'd524, 5'b01100});
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    check_val("A_restart", {a_x, a_y, a_tick, a_fs}, {10'd0, 10'd0, 2'b11});
`ifdef VGA_SYNC_TEST_PATTERN_EN
    wait_a_x(160, 0, ok);
    check_val("A_rgb_x160", {ok, a_rgb}, {1'b1, 12'h0FF});
    wait_a_x(700, 0, ok);
    check_val("A_rgb_x700", {ok, a_rgb}, {1'b1, 12'h000});
`endif
  endtask

  task automatic b_seq();
    int cnt = 0;
    int vmin = 1023;
    int vmax = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = b_fs;
    end
    check_val("B_first_fs", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (b_tick) cnt++;
      if (!b_vs) begin
        if (b_y < vmin) vmin = b_y;
        if (b_y > vmax) vmax = b_y;
      end
      seen = b_fs;
    end
    check_val("B_frame_ticks", cnt, 360);
    check_val("B_vsync_first", vmin, 10);
    check_val("B_vsync_last", vmax, 11);

    repeat (12) begin
      repeat ($urandom_range(20, 500)) @(negedge clk);
      rst_b = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_b = 1'b0;
    end
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (b_tick) cnt++;
    end
    check_val("B_tick_always", cnt, 50);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check_val("A_reset", {a_x, a_y, a_tick, a_fs, a_hs, a_vs, a_von},
              {10'd799, 10'd524, 5'b00110});
    check_val("A_reset_rgb", a_rgb, 12'h000);
    check_val("B_reset", {b_x, b_y, b_tick, b_fs, b_hs, b_vs, b_von},
              {10'd23, 10'd14, 5'b00110});
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      a_seq();
      b_seq();
    join
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_vga_sync_gen
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 raster timing from the 100 MHz system clock.
- Uses an internal pixel clock-enable instead of a derived clock, so downstream pixel logic stays in the system clock domain.
- Outputs are registered hsync/vsync, video_on, the pixel coordinates, and per-pixel/per-frame strobes.
- Sits between the game-state logic and the VGA connector.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1); 4 gives 25 MHz pixel rate.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- pixel_tick  out  1  one-clk strobe; x/y/sync/video_on present a new pixel in this cycle.
- frame_start  out  1  one-clk strobe, coincident with the pixel_tick that moves to (0,0).
- hsync  out  1  horizontal sync, polarity set by SYNC_ACTIVE.
- vsync  out  1  vertical sync, polarity set by SYNC_ACTIVE.
- video_on  out  1  high when x<H_VISIBLE and y<V_VISIBLE.
- x  out  10  current column, 0..H_TOTAL-1.
- y  out  10  current line, 0..V_TOTAL-1.

Behaviour:
- Derived values: H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Clock-enable divider: div_cnt counts 0..CLK_DIV-1, then wraps to 0. The internal enable is high when div_cnt==CLK_DIV-1. With CLK_DIV=1 the enable is permanently high.
- On each enable, at that clk edge:
  - x <= (x==H_TOTAL-1) ? 0 : x+1.
  - y advances only when x wraps: y <= (y==V_TOTAL-1) ? 0 : y+1.
  - pixel_tick <= 1.
  - frame_start <= 1 exactly when the new (x,y) is (0,0).
  - In all other cycles, pixel_tick and frame_start are 0.
- Sync and video decode uses the next x/y values, registered, so it is aligned with x/y in the same cycle (zero skew):
  - hsync asserted for H_VISIBLE+H_FRONT <= x <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751).
  - vsync asserted for V_VISIBLE+V_FRONT <= y <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491).
- Between enables, all outputs hold their value.
- Reset values:
  - div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1.
  - hsync=vsync=~SYNC_ACTIVE, video_on=0, pixel_tick=0, frame_start=0.
  - This parks the raster on the last back-porch pixel.
- After reset release, the first enable occurs at the CLK_DIV-th rising edge. It moves to (0,0) with video_on=1 and pixel_tick=frame_start=1.
- Reset mid-frame takes priority over any enable in the same cycle. All state returns to the reset values; no partial line is resumed.
- Counter widths are 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.

Optional Feature:
- Macro: VGA_SYNC_TEST_PATTERN_EN.
- Defined:
  - Adds output port rgb (out, 12 bits, 4:4:4), registered and updated on the same edge as x/y.
  - Produces 8 vertical colour bars, each H_VISIBLE/8 pixels wide (80). Bar index = x/80; colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - rgb=12'h000 whenever video_on=0 and during reset.
- Undefined: no rgb port and no pattern logic.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480 timing constants;
  - H_TOTAL and V_TOTAL;
  - coordinate width constant COORD_W=10;
  - the 8-entry colour-bar constant table.
- Sub-module pixel_tick_gen (parameter CLK_DIV; ports clk, reset, tick) holds the clock-enable divider. It replaces derived-clock usage for pixel timing.

Test Plan:
- Reset held for 3 clks, then released -> all outputs equal their reset values during reset; at release+4 clks, x=0, y=0, video_on=1, pixel_tick=1, frame_start=1.
- Run one line with CLK_DIV=4 -> pixel_tick high exactly 1 clk in every 4; x steps 0..799 then wraps to 0; y goes 0->1 on the wrap; hsync low only for x=656..751.
- Run a full frame -> vsync low only for y=490..491; video_on=0 for x>=640 or y>=480; next frame_start is 420000 pixel_ticks after the first.
- Assert reset at (x=300, y=200) for 1 clk -> x=799, y=524, video_on=0, syncs high; the next tick lands at (0,0) with frame_start=1.
- CLK_DIV=1 -> pixel_tick constantly 1 after release; x increments every clk; sync windows unchanged in pixel units.
- With VGA_SYNC_TEST_PATTERN_EN defined -> rgb=FFF at x=0, 0FF at x=160, 000 at x=700 (blanking), 000 at y=500.
